powlib_packup: RTL and testbench
================================

# powlib_packup

Width up-converter that packs R consecutive W-bit beats into one W*R-bit word with a per-lane valid mask and end-of-packet flag. Sits directly downstream of powlib_sfifo/powlib_afifo read ports (FIFO rddata/rdvld/rdrdy drive wrdata/wrvld/wrrdy) and feeds wider datapaths such as bus-width adapters. A `wrlast` flush closes a partial word early. Registered output with a valid/ready handshake on both sides, one clock domain.

## Interface
- W, 16, input beat width in bits
- R, 4, beats per output word; R>=2, need not be a power of 2
- EDBG, 0, nonzero enables elaboration checks and debug $display
- ID, "PACKUP", string identifier used in debug messages
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- wrdata  input  W  input beat
- wrlast  input  1  beat is last of packet; qualified by wrvld
- wrvld  input  1  input beat valid
- wrrdy  output  1  block accepts input beat this cycle
- rddata  output  W*R  packed word; lane i = bits [W*i +: W], lane 0 = first beat
- rdmask  output  R  bit i set = lane i holds a valid beat
- rdlast  output  1  word was closed by wrlast
- rdvld  output  1  output word valid
- rdrdy  input  1  consumer accepts output word

## Operation
- State: accumulator acc[W*R], lane mask amask[R], lane counter cnt (width clogb2(R), range 0..R-1), output register {rddata, rdmask, rdlast, rdvld}.
- Reset (rst=0, async): acc=0, amask=0, cnt=0, rddata=0, rdmask=0, rdlast=0, rdvld=0. Reset mid-word discards the partial word and any held output word without emitting.
- wrrdy = !rdvld || rdrdy (combinational; output register free or draining this cycle). Independent of wrvld/wrlast.
- Accept (wrinc = wrvld && wrrdy): beat written to lane cnt.
- Completion: wrinc && (cnt==R-1 || wrlast).
  - On completion edge: output register loads acc with lane cnt replaced by wrdata; rdmask = amask | (1<<cnt); rdlast = wrlast; rdvld=1. acc, amask cleared to 0, cnt cleared to 0.
  - Lanes above cnt on an early (wrlast) close are 0 in rddata and 0 in rdmask.
- Non-completing accept: acc lane cnt <= wrdata, amask[cnt] <= 1, cnt <= cnt+1.
- Output drain (rdvld && rdrdy) with no completion same cycle: rdvld <= 0; rddata/rdmask/rdlast hold last value (don't-care, not cleared).
- Simultaneous drain and completion: new word loaded, rdvld stays 1; no bubble.
- wrlast on cnt==R-1: single completion, rdmask all ones, rdlast=1.
- wrlast on first beat (cnt==0): word with rdmask=1, rdlast=1.
- Output register holds stable while rdvld && !rdrdy (rddata, rdmask, rdlast unchanged).
- wrlast ignored when wrvld=0 or wrrdy=0.
- EDBG!=0: elaboration prints ID, R and $finish if R<2.

## Timing
- Latency: completing beat accepted at edge k -> rdvld=1 and word visible after edge k (1 cycle).
- Throughput: one input beat per cycle sustained while rdrdy=1; one output word per R input cycles (full words).
- Backpressure: rdrdy=0 with rdvld=1 drops wrrdy the same cycle; input stalls at any cnt, accumulator holds.
- No combinational path from wrvld/wrdata/wrlast to any output; only path is rdrdy -> wrrdy.

## Test plan
- Full words, W=16 R=4, rdrdy=1, stream 0x0001..0x0008 continuous: two words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, rdmask=4'b1111, rdlast=0, rdvld pulses after edges 4 and 8, wrrdy never low.
- Early flush: beats 0xAAAA, 0xBBBB with wrlast on second: rddata=0x0000_0000_BBBB_AAAA, rdmask=4'b0011, rdlast=1; next beat lands in lane 0.
- Backpressure: rdrdy=0 while 5 beats offered: first word held stable, wrrdy=0 after 4th accept, 5th beat not accepted until rdrdy=1; no data loss or duplication versus reference model.
- Simultaneous drain/complete: rdrdy=1 on the edge a new word completes: rdvld stays 1, new word replaces old, consumer sees both words in order.
- Reset mid-word: accept 2 beats, pulse rst=0 asynchronously between edges: all outputs 0 immediately, cnt=0; next 4 beats form a clean word with rdmask=4'b1111.
- Odd R=3 with upstream powlib_sfifo (D=8), random wrvld/rdrdy, wrlast random: scoreboard matches packing, lane order, masks over 1000 beats.

Source files
------------

// File: rtl/powlib_packup.sv
// Width up-converter: packs R consecutive W-bit beats into one W*R-bit word.
// A wrlast beat closes a partial word early. The output word is registered.
module powlib_packup #(
   parameter int unsigned W    = 16,
   parameter int unsigned R    = 4,
   parameter int          EDBG = 0,
   parameter              ID   = "PACKUP"
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   wrdata,
   input  logic           wrlast,
   input  logic           wrvld,
   output logic           wrrdy,
   output logic [W*R-1:0] rddata,
   output logic [R-1:0]   rdmask,
   output logic           rdlast,
   output logic           rdvld,
   input  logic           rdrdy
);

   localparam int unsigned CW = $clog2(R);

   if (EDBG != 0) begin : g_dbg
      $info("%s: packup R=%0d", ID, R);
      if (R < 2) begin : g_bad_r
         $fatal(1, "%s: R=%0d must be at least 2", ID, R);
      end
   end

   logic [W*R-1:0] acc_q, acc_d;
   logic [R-1:0]   amask_q, amask_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W*R-1:0] rddata_q, rddata_d;
   logic [R-1:0]   rdmask_q, rdmask_d;
   logic           rdlast_q, rdlast_d;
   logic           rdvld_q, rdvld_d;

   logic           wrinc;
   logic           done;
   logic [W*R-1:0] word;
   logic [R-1:0]   word_mask;

   // Output register is free when empty or being drained this cycle.
   assign wrrdy = !rdvld_q || rdrdy;
   assign wrinc = wrvld && wrrdy;
   assign done  = wrinc && ((cnt_q == CW'(R - 1)) || wrlast);

   always_comb begin
      word                       = acc_q;
      word[W*int'(cnt_q) +: W]   = wrdata;
      word_mask                  = amask_q | (R'(1) << cnt_q);
   end

   always_comb begin
      acc_d    = acc_q;
      amask_d  = amask_q;
      cnt_d    = cnt_q;
      rddata_d = rddata_q;
      rdmask_d = rdmask_q;
      rdlast_d = rdlast_q;
      rdvld_d  = rdvld_q && !rdrdy;
      if (done) begin
         // Accumulator is zero above cnt, so an early close leaves upper lanes 0.
         rddata_d = word;
         rdmask_d = word_mask;
         rdlast_d = wrlast;
         rdvld_d  = 1'b1;
         acc_d    = '0;
         amask_d  = '0;
         cnt_d    = '0;
      end else if (wrinc) begin
         acc_d    = word;
         amask_d  = word_mask;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= '0;
         amask_q  <= '0;
         cnt_q    <= '0;
         rddata_q <= '0;
         rdmask_q <= '0;
         rdlast_q <= 1'b0;
         rdvld_q  <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         amask_q  <= amask_d;
         cnt_q    <= cnt_d;
         rddata_q <= rddata_d;
         rdmask_q <= rdmask_d;
         rdlast_q <= rdlast_d;
         rdvld_q  <= rdvld_d;
      end
   end

   assign rddata = rddata_q;
   assign rdmask = rdmask_q;
   assign rdlast = rdlast_q;
   assign rdvld  = rdvld_q;

endmodule

// File: tb/tb_powlib_packup.sv
// Bench for powlib_packup (W=16, R=4): directed vectors plus a random stretch,
// checked every cycle against a beat-list model and at key points against literals.
module tb_powlib_packup;

   localparam int unsigned W = 16;
   localparam int unsigned R = 4;

   logic           clk;
   logic           rst;
   logic [W-1:0]   wrdata;
   logic           wrlast;
   logic           wrvld;
   logic           wrrdy;
   logic [W*R-1:0] rddata;
   logic [R-1:0]   rdmask;
   logic           rdlast;
   logic           rdvld;
   logic           rdrdy;

   int total = 0;
   int bad   = 0;

   powlib_packup #(
      .W(W),
      .R(R)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .wrdata (wrdata),
      .wrlast (wrlast),
      .wrvld  (wrvld),
      .wrrdy  (wrrdy),
      .rddata (rddata),
      .rdmask (rdmask),
      .rdlast (rdlast),
      .rdvld  (rdvld),
      .rdrdy  (rdrdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Model: list of beats of the word being built, plus the held output word.
   logic [W-1:0]   beats[$];
   logic           m_full;
   logic [W*R-1:0] m_data;
   logic [R-1:0]   m_mask;
   logic           m_last;

   initial begin
      m_full = 1'b0;
      m_data = '0;
      m_mask = '0;
      m_last = 1'b0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_full = 1'b0;
            m_data = '0;
            m_mask = '0;
            m_last = 1'b0;
            beats.delete();
         end else if (clk) begin
            logic take;
            take = wrvld && (!m_full || rdrdy);
            if (m_full && rdrdy) m_full = 1'b0;
            if (take) begin
               beats.push_back(wrdata);
               if (beats.size() == R || wrlast) begin
                  m_data = '0;
                  m_mask = '0;
                  foreach (beats[i]) begin
                     m_data[i*W +: W] = beats[i];
                     m_mask[i]        = 1'b1;
                  end
                  m_last = wrlast;
                  m_full = 1'b1;
                  beats.delete();
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("reset_rdvld", 64'(rdvld), 64'd0);
         check("reset_rddata", rddata, 64'd0);
      end else begin
         check("wrrdy", 64'(wrrdy), 64'(!m_full || rdrdy));
         check("rdvld", 64'(rdvld), 64'(m_full));
         if (m_full) begin
            check("rddata", rddata, m_data);
            check("rdmask", 64'(rdmask), 64'(m_mask));
            check("rdlast", 64'(rdlast), 64'(m_last));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] d, input logic l);
      wrvld  = 1'b1;
      wrdata = d;
      wrlast = l;
      step();
   endtask

   task automatic idle();
      wrvld  = 1'b0;
      wrlast = 1'b0;
      step();
   endtask

   initial begin
      rst    = 1'b0;
      wrdata = '0;
      wrlast = 1'b0;
      wrvld  = 1'b0;
      rdrdy  = 1'b1;
      repeat (3) step();
      check("rst_mask", 64'(rdmask), 64'd0);
      check("rst_last", 64'(rdlast), 64'd0);
      check("rst_wrrdy", 64'(wrrdy), 64'd1);
      rst = 1'b1;
      step();

      // Full words, continuous stream
      for (int i = 1; i <= 8; i++) begin
         beat(W'(i), 1'b0);
         if (i == 4) begin
            check("full1_data", rddata, 64'h0004_0003_0002_0001);
            check("full1_mask", 64'(rdmask), 64'hF);
            check("full1_vld", 64'(rdvld), 64'd1);
         end
         if (i == 8) check("full2_data", rddata, 64'h0008_0007_0006_0005);
         if (i == 5) check("full_gap_vld", 64'(rdvld), 64'd0);
      end
      idle();
      check("drained", 64'(rdvld), 64'd0);

      // Early flush, then lane 0 restart
      beat(16'hAAAA, 1'b0);
      beat(16'hBBBB, 1'b1);
      check("flush_data", rddata, 64'h0000_0000_BBBB_AAAA);
      check("flush_mask", 64'(rdmask), 64'h3);
      check("flush_last", 64'(rdlast), 64'd1);
      wrvld  = 1'b0;
      wrlast = 1'b1;
      step();
      beat(16'h1111, 1'b0);
      beat(16'h2222, 1'b0);
      beat(16'h3333, 1'b0);
      beat(16'h4444, 1'b0);
      check("after_flush", rddata, 64'h4444_3333_2222_1111);
      check("after_flush_last", 64'(rdlast), 64'd0);
      beat(16'h5555, 1'b1);
      check("first_last_data", rddata, 64'h0000_0000_0000_5555);
      check("first_last_mask", 64'(rdmask), 64'h1);
      beat(16'h6661, 1'b0);
      beat(16'h6662, 1'b0);
      beat(16'h6663, 1'b0);
      beat(16'h6664, 1'b1);
      check("last_on_full_mask", 64'(rdmask), 64'hF);
      check("last_on_full_last", 64'(rdlast), 64'd1);
      idle();

      // Backpressure
      rdrdy = 1'b0;
      for (int i = 0; i < 4; i++) beat(W'(16'h10 + i), 1'b0);
      check("bp_vld", 64'(rdvld), 64'd1);
      check("bp_wrrdy", 64'(wrrdy), 64'd0);
      for (int i = 0; i < 3; i++) begin
         beat(16'h14, 1'b0);
         check("bp_hold", rddata, 64'h0013_0012_0011_0010);
      end
      rdrdy = 1'b1;
      beat(16'h14, 1'b0);
      check("bp_drain", 64'(rdvld), 64'd0);
      beat(16'h15, 1'b0);
      beat(16'h16, 1'b0);
      beat(16'h17, 1'b0);
      check("bp_next", rddata, 64'h0017_0016_0015_0014);

      // Simultaneous drain and completion
      for (int i = 1; i <= 3; i++) begin
         beat(W'(16'h20 + i), 1'b1);
         check("sim_vld", 64'(rdvld), 64'd1);
         check("sim_data", rddata, 64'(16'h20 + i));
      end
      idle();

      // Reset mid-word
      beat(16'h31, 1'b0);
      beat(16'h32, 1'b0);
      wrvld = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("mid_rst_data", rddata, 64'd0);
      check("mid_rst_mask", 64'(rdmask), 64'd0);
      check("mid_rst_vld", 64'(rdvld), 64'd0);
      #3 rst = 1'b1;
      step();
      for (int i = 1; i <= 4; i++) beat(W'(16'h40 + i), 1'b0);
      check("post_rst_data", rddata, 64'h0044_0043_0042_0041);
      check("post_rst_mask", 64'(rdmask), 64'hF);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         wrvld  = ($urandom_range(9) < 7);
         rdrdy  = ($urandom_range(9) < 6);
         wrlast = ($urandom_range(9) < 2);
         wrdata = W'($urandom);
         step();
      end
      wrvld = 1'b0;
      rdrdy = 1'b1;
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
